pll_lock_supervisor: RTL and testbench

//  Drives the rPLL RESET input and consumes its LOCK output.

---
 rtl/pll_lock_supervisor.sv | 137 +++++++++++++
 tb/tb_pll_lock_supervisor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL start-up and lock supervisor: pulses the rPLL reset, waits for lock with timeout/retry,
// qualifies lock stability and releases a stretched system reset; re-runs on lock loss.
module pll_lock_supervisor #(
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT = 12000,
    parameter int LOCK_STABLE  = 1200,
    parameter int RST_STRETCH  = 64,
    parameter int MAX_RETRIES  = 3
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_reset,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_lost_cnt
);

    localparam int MAX_A   = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B   = (LOCK_STABLE > RST_STRETCH) ? LOCK_STABLE : RST_STRETCH;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] STR_LAST = CNT_W'(RST_STRETCH - 1);
    localparam logic [3:0]       RETRY_LIM = 4'(MAX_RETRIES);

    localparam logic [2:0] PLL_RST   = 3'd0;
    localparam logic [2:0] WAIT_LOCK = 3'd1;
    localparam logic [2:0] STABLE    = 3'd2;
    localparam logic [2:0] RELEASE   = 3'd3;
    localparam logic [2:0] RUN       = 3'd4;
    localparam logic [2:0] FAIL      = 3'd5;

    logic [2:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [3:0]       retry_nx;
    logic [7:0]       lost_nx, lost_inc;
    logic             lock_meta, lock_s;

    // LOCK comes from the PLL's own clock domain; only lock_s is used below.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    assign lost_inc = (lock_lost_cnt == 8'hFF) ? 8'hFF : lock_lost_cnt + 8'd1;

    always_comb begin
        state_nx = state;
        retry_nx = retry_cnt;
        lost_nx  = lock_lost_cnt;
        case (state)
            PLL_RST: begin
                if (cnt == RST_LAST) state_nx = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nx = STABLE;
                end else if (cnt == TMO_LAST) begin
                    if (retry_cnt == RETRY_LIM) begin
                        state_nx = FAIL;
                    end else begin
                        retry_nx = retry_cnt + 4'd1;
                        state_nx = PLL_RST;
                    end
                end
            end
            STABLE: begin
                if (!lock_s) state_nx = WAIT_LOCK;
                else if (cnt == STB_LAST) state_nx = RELEASE;
            end
            RELEASE: begin
                if (!lock_s) begin
                    lost_nx  = lost_inc;
                    retry_nx = 4'd0;
                    state_nx = PLL_RST;
                end else if (cnt == STR_LAST) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                // A relock request landing on a lock loss restarts once but still counts the loss.
                if (!lock_s || relock_req) begin
                    retry_nx = 4'd0;
                    state_nx = PLL_RST;
                    if (!lock_s) lost_nx = lost_inc;
                end
            end
            FAIL: begin
                if (relock_req) begin
                    retry_nx = 4'd0;
                    state_nx = PLL_RST;
                end
            end
            default: state_nx = PLL_RST;
        endcase

        if (state_nx != state) cnt_nx = '0;
        else if (state == RUN || state == FAIL) cnt_nx = cnt;
        else cnt_nx = cnt + 1'b1;
    end

    // Outputs decode the next state so they change on the same edge as the state register.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state         <= PLL_RST;
            cnt           <= '0;
            retry_cnt     <= 4'd0;
            lock_lost_cnt <= 8'd0;
            pll_reset     <= 1'b1;
            sys_rst       <= 1'b1;
            ready         <= 1'b0;
            fail          <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            retry_cnt     <= retry_nx;
            lock_lost_cnt <= lost_nx;
            pll_reset     <= (state_nx == PLL_RST) || (state_nx == FAIL);
            sys_rst       <= (state_nx != RUN);
            ready         <= (state_nx == RUN);
            fail          <= (state_nx == FAIL);
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small parameters; expected values are hand-derived
// edge counts from the moment each input changes.
module tb_pll_lock_supervisor;

    logic       clkin = 1'b0;
    logic       reset = 1'b1;
    logic       pll_lock = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_reset, sys_rst, ready, fail;
    logic [3:0] retry_cnt;
    logic [7:0] lock_lost_cnt;

    int checks = 0;
    int failures = 0;

    pll_lock_supervisor #(
        .RESET_CYCLES(4),
        .LOCK_TIMEOUT(20),
        .LOCK_STABLE (8),
        .RST_STRETCH (5),
        .MAX_RETRIES (2)
    ) dut (
        .clkin        (clkin),
        .reset        (reset),
        .pll_lock     (pll_lock),
        .relock_req   (relock_req),
        .pll_reset    (pll_reset),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .fail         (fail),
        .retry_cnt    (retry_cnt),
        .lock_lost_cnt(lock_lost_cnt)
    );

    always #5 clkin = ~clkin;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_reset"}, 32'(pll_reset), 32'd1);
        check({tag, "_sys_rst"}, 32'(sys_rst), 32'd1);
        check({tag, "_ready"}, 32'(ready), 32'd0);
        check({tag, "_fail"}, 32'(fail), 32'd0);
        check({tag, "_retry"}, 32'(retry_cnt), 32'd0);
        check({tag, "_lost"}, 32'(lock_lost_cnt), 32'd0);
    endtask

    // Output invariants, checked whenever ready or fail is up.
    always @(negedge clkin) begin
        if (!reset && ready) check("inv_ready_rsts", 32'({sys_rst, pll_reset, fail}), 32'd0);
        if (!reset && fail) check("inv_fail_ready", 32'(ready), 32'd0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_pr;
        logic [3:0] exp_retry;

        // Reset values and first pll_reset pulse.
        repeat (3) step();
        check_reset_values("rst");
        reset = 1'b0;
        repeat (3) step();
        check("t1_pll_reset_hi", 32'(pll_reset), 32'd1);
        step();
        check("t1_pll_reset_lo", 32'(pll_reset), 32'd0);

        // Lock rises 10 edges after reset release: ready at +16 edges from the drive.
        repeat (6) step();
        pll_lock = 1'b1;
        repeat (15) step();
        check("t1_ready_early", 32'(ready), 32'd0);
        check("t1_sysrst_early", 32'(sys_rst), 32'd1);
        step();
        check("t1_ready", 32'(ready), 32'd1);
        check("t1_sys_rst", 32'(sys_rst), 32'd0);
        check("t1_retry", 32'(retry_cnt), 32'd0);

        // Lock loss in RUN for 3 cycles.
        pll_lock = 1'b0;
        repeat (2) step();
        check("t4_ready_still", 32'(ready), 32'd1);
        step();
        pll_lock = 1'b1;
        check("t4_ready_drop", 32'(ready), 32'd0);
        check("t4_sys_rst", 32'(sys_rst), 32'd1);
        check("t4_lost", 32'(lock_lost_cnt), 32'd1);
        repeat (3) step();
        check("t4_pulse_hi", 32'(pll_reset), 32'd1);
        step();
        check("t4_pulse_lo", 32'(pll_reset), 32'd0);
        repeat (13) step();
        check("t4_ready_early", 32'(ready), 32'd0);
        step();
        check("t4_relocked", 32'(ready), 32'd1);

        // Lock toggling every 5 cycles never qualifies.
        for (int i = 0; i < 80; i++) begin
            pll_lock = ((i / 5) % 2) == 1;
            step();
            if (i >= 10) check("t5_sys_rst", 32'(sys_rst), 32'd1);
        end
        check("t5_retry", 32'(retry_cnt), 32'd0);
        check("t5_lost", 32'(lock_lost_cnt), 32'd2);

        // Lock never rises: pulses at edges 0-3, 24-27, 48-51, FAIL from 72.
        pll_lock = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            step();
            exp_pr = (k < 4) || (k >= 24 && k < 28) || (k >= 48 && k < 52) || (k >= 72);
            exp_retry = (k < 24) ? 4'd0 : (k < 48) ? 4'd1 : 4'd2;
            check("t2_pll_reset", 32'(pll_reset), 32'(exp_pr));
            check("t2_retry", 32'(retry_cnt), 32'(exp_retry));
            check("t2_fail", 32'(fail), 32'(k >= 72));
        end
        check("t2_sys_rst", 32'(sys_rst), 32'd1);

        // Recover from FAIL with relock_req.
        relock_req = 1'b1;
        step();
        relock_req = 1'b0;
        pll_lock = 1'b1;
        check("t3_fail_clr", 32'(fail), 32'd0);
        check("t3_retry_clr", 32'(retry_cnt), 32'd0);
        check("t3_pll_reset", 32'(pll_reset), 32'd1);
        repeat (17) step();
        check("t3_ready_early", 32'(ready), 32'd0);
        step();
        check("t3_ready", 32'(ready), 32'd1);

        // relock_req in RUN restarts without counting a loss.
        relock_req = 1'b1;
        step();
        relock_req = 1'b0;
        check("rl_ready", 32'(ready), 32'd0);
        check("rl_pll_reset", 32'(pll_reset), 32'd1);
        check("rl_lost", 32'(lock_lost_cnt), 32'd0);
        repeat (18) step();
        check("rl_ready_back", 32'(ready), 32'd1);

        // 256 RUN lock losses; the first coincides with relock_req.
        for (int i = 0; i < 256; i++) begin
            pll_lock = 1'b0;
            repeat (2) step();
            relock_req = (i == 0);
            step();
            relock_req = 1'b0;
            pll_lock = 1'b1;
            check("t6_lost", 32'(lock_lost_cnt), (i < 255) ? 32'(i + 1) : 32'd255);
            check("t6_sys_rst", 32'(sys_rst), 32'd1);
            repeat (18) step();
            check("t6_ready", 32'(ready), 32'd1);
        end

        // Async reset while in STABLE, observed before any clock edge.
        pll_lock = 1'b0;
        repeat (3) step();
        pll_lock = 1'b1;
        repeat (7) step();
        check("t6_mid_sys_rst", 32'(sys_rst), 32'd1);
        check("t6_mid_pll_reset", 32'(pll_reset), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async");
        step();
        reset = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
